fp_mult_core: RTL

FP_MULT_CORE -- requirements
Module: fp_mult_core

---
 rtl/fp_mult_core_if.sv | 28 ++
 rtl/fp_mult_core.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/fp_mult_core_if.sv
`default_nettype none
// ============================================================================
// Module      : fp_mult_core_if
// Description : Request/response bundle for the binary32 multiplier core.
// Revision    : 1.0 - initial release
// ============================================================================
interface fp_mult_core_if;
    logic        start;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        ovf;
    logic        unf;
    logic        inv;

    modport master (
        output start, op_a, op_b,
        input  busy, done, result, ovf, unf, inv
    );

    modport slave (
        input  start, op_a, op_b,
        output busy, done, result, ovf, unf, inv
    );
endinterface
`default_nettype wire

// File: rtl/fp_mult_core.sv
`default_nettype none
// ============================================================================
// Module      : fp_mult_core
// Description : Iterative IEEE-754 binary32 multiplier, shift-add significand
//               product over 24 cycles, RNE rounding, fixed 26-cycle latency.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_mult_core (
    input  logic               clk,
    input  logic               rst_n,
    fp_mult_core_if.slave      bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MULT = 2'd1;
    localparam logic [1:0] S_NORM = 2'd2;

    localparam logic [4:0] LAST_ITER = 5'd23;
    localparam logic [9:0] BIAS      = 10'd127;
    localparam logic [9:0] EXP_MAX   = 10'd255;

    logic [1:0]  state;
    logic [4:0]  cnt;
    logic [47:0] acc;
    logic [47:0] mcand;
    logic [23:0] mplier;
    logic        sign;
    logic [7:0]  exp_a;
    logic [7:0]  exp_b;
    logic        spec_nan;
    logic        spec_inf;
    logic        spec_zero;
    logic        done;
    logic [31:0] result;
    logic        ovf;
    logic        unf;
    logic        inv;

    // ------------------------------------------------------------------
    // Operand classification at acceptance (denormals count as zero)
    // ------------------------------------------------------------------
    logic        a_zero, a_inf, a_nan;
    logic        b_zero, b_inf, b_nan;
    logic [23:0] sig_a_in, sig_b_in;
    logic        accept;

    always_comb begin
        a_zero   = (bus.op_a[30:23] == 8'h00);
        b_zero   = (bus.op_b[30:23] == 8'h00);
        a_inf    = (bus.op_a[30:23] == 8'hFF) && (bus.op_a[22:0] == 23'd0);
        b_inf    = (bus.op_b[30:23] == 8'hFF) && (bus.op_b[22:0] == 23'd0);
        a_nan    = (bus.op_a[30:23] == 8'hFF) && (bus.op_a[22:0] != 23'd0);
        b_nan    = (bus.op_b[30:23] == 8'hFF) && (bus.op_b[22:0] != 23'd0);
        sig_a_in = a_zero ? 24'd0 : {1'b1, bus.op_a[22:0]};
        sig_b_in = b_zero ? 24'd0 : {1'b1, bus.op_b[22:0]};
    end

    // The done cycle still counts as busy, so a start there is ignored.
    assign accept = (state == S_IDLE) && bus.start && !done;

    // ------------------------------------------------------------------
    // Normalisation and rounding of the finished 48-bit product
    // ------------------------------------------------------------------
    logic        prod_hi;
    logic [23:0] mant24;
    logic        guard_bit, round_bit, sticky_bit, round_up;
    logic [24:0] mant_rnd;
    logic        rnd_carry;
    logic [22:0] frac_out;
    logic [9:0]  exp_sum;
    logic        exp_ovf, exp_unf;
    logic [31:0] result_nxt;
    logic        ovf_nxt, unf_nxt, inv_nxt;

    always_comb begin
        prod_hi    = acc[47];
        mant24     = prod_hi ? acc[47:24] : acc[46:23];
        guard_bit  = prod_hi ? acc[23] : acc[22];
        round_bit  = prod_hi ? acc[22] : acc[21];
        sticky_bit = prod_hi ? (|acc[21:0]) : (|acc[20:0]);
        round_up   = guard_bit & (round_bit | sticky_bit | mant24[0]);
        mant_rnd   = {1'b0, mant24} + {24'd0, round_up};
        rnd_carry  = mant_rnd[24];
        frac_out   = rnd_carry ? mant_rnd[23:1] : mant_rnd[22:0];

        // Ten-bit two's complement: bit 9 set means the exponent went negative.
        exp_sum    = {2'b00, exp_a} + {2'b00, exp_b} - BIAS
                   + {9'd0, prod_hi} + {9'd0, rnd_carry};
        exp_ovf    = !exp_sum[9] && (exp_sum >= EXP_MAX);
        exp_unf    = exp_sum[9] || (exp_sum == 10'd0);

        result_nxt = {sign, exp_sum[7:0], frac_out};
        ovf_nxt    = 1'b0;
        unf_nxt    = 1'b0;
        inv_nxt    = 1'b0;

        if (spec_nan) begin
            result_nxt = 32'h7FC0_0000;
            inv_nxt    = 1'b1;
        end else if (spec_inf) begin
            result_nxt = {sign, 31'h7F80_0000};
        end else if (spec_zero) begin
            result_nxt = {sign, 31'd0};
        end else if (exp_ovf) begin
            result_nxt = {sign, 31'h7F80_0000};
            ovf_nxt    = 1'b1;
        end else if (exp_unf) begin
            result_nxt = {sign, 31'd0};
            unf_nxt    = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= 5'd0;
            acc       <= 48'd0;
            mcand     <= 48'd0;
            mplier    <= 24'd0;
            sign      <= 1'b0;
            exp_a     <= 8'd0;
            exp_b     <= 8'd0;
            spec_nan  <= 1'b0;
            spec_inf  <= 1'b0;
            spec_zero <= 1'b0;
            done      <= 1'b0;
            result    <= 32'd0;
            ovf       <= 1'b0;
            unf       <= 1'b0;
            inv       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        state     <= S_MULT;
                        cnt       <= 5'd0;
                        acc       <= 48'd0;
                        mcand     <= {24'd0, sig_a_in};
                        mplier    <= sig_b_in;
                        sign      <= bus.op_a[31] ^ bus.op_b[31];
                        exp_a     <= bus.op_a[30:23];
                        exp_b     <= bus.op_b[30:23];
                        spec_nan  <= a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
                        spec_inf  <= a_inf | b_inf;
                        spec_zero <= a_zero | b_zero;
                    end
                end
                S_MULT: begin
                    if (mplier[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand  <= {mcand[46:0], 1'b0};
                    mplier <= {1'b0, mplier[23:1]};
                    cnt    <= cnt + 5'd1;
                    if (cnt == LAST_ITER) begin
                        state <= S_NORM;
                    end
                end
                S_NORM: begin
                    state  <= S_IDLE;
                    done   <= 1'b1;
                    result <= result_nxt;
                    ovf    <= ovf_nxt;
                    unf    <= unf_nxt;
                    inv    <= inv_nxt;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = (state != S_IDLE) || done;
    assign bus.done   = done;
    assign bus.result = result;
    assign bus.ovf    = ovf;
    assign bus.unf    = unf;
    assign bus.inv    = inv;

endmodule
`default_nettype wire
